// File: rtl/prog_counter_bus.sv
// prog_counter_bus
//   Parametrised up/down program counter with a programmable wrap limit and a
//   parallel load taken from a shared bidirectional bus. A load runs through a
//   short FSM. IDLE waits for a load edge. RELEASE keeps the bus undriven for
//   TURN cycles. CAPTURE then samples bus_in_i into the counter.
//
//   Optional feature macro: PROG_COUNTER_SATURATE_EN
//     defined   : steps at the limit hold the value, and tc_o pulses on every
//                 step that is attempted at the limit.
//     undefined : steps at the limit wrap (up: MAX->0, down: 0->MAX), and tc_o
//                 pulses after each wrap.
//
// Parameters
//   WIDTH  counter/bus width (2..32)
//   MAX    wrap limit, truncated to WIDTH bits; counts run 0..MAX
//   TURN   bus turnaround cycles before capture (1..15)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   en_i       in   1      count enable (synchronised internally)
//   dir_i      in   1      direction, 1=up 0=down (synchronised)
//   load_i     in   1      load request, rising edge starts a load (synchronised)
//   oe_i       in   1      bus output-enable request (synchronised)
//   bus_in_i   in   WIDTH  bus input path, sampled in CAPTURE
//   bus_out_o  out  WIDTH  bus output path, equals count_o
//   bus_oe_o   out  WIDTH  bus output enable, all bits equal
//   count_o    out  WIDTH  current counter value
//   tc_o       out  1      terminal-count pulse, one cycle
//   busy_o     out  1      load sequence in progress
module prog_counter_bus #(
  parameter int unsigned WIDTH = 8,
  parameter logic [63:0] MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned TURN  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic             oe_i,
  input  logic [WIDTH-1:0] bus_in_i,
  output logic [WIDTH-1:0] bus_out_o,
  output logic [WIDTH-1:0] bus_oe_o,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             busy_o
);

  localparam logic [WIDTH-1:0] MAX_W     = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       TURN_INIT = 4'(TURN - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RELEASE = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       turn_cnt_q;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;

  logic             en_q;
  logic             dir_q;
  logic             load_q;
  logic             load_hist_q;
  logic             oe_q;

  logic             load_pulse_s;
  logic [WIDTH-1:0] step_d;
  logic             step_lim_d;

  assign load_pulse_s = load_q & ~load_hist_q;

  // Next value for one enabled step, plus a flag that marks a step at the limit.
  always_comb begin
    step_d     = count_q;
    step_lim_d = 1'b0;
    if (dir_q) begin
      // Loaded values above MAX also count as being at the limit.
      if (count_q >= MAX_W) begin
        step_lim_d = 1'b1;
`ifdef PROG_COUNTER_SATURATE_EN
        step_d     = count_q;
`else
        step_d     = ZERO_W;
`endif
      end else begin
        step_d     = count_q + ONE_W;
      end
    end else begin
      if (count_q == ZERO_W) begin
        step_lim_d = 1'b1;
`ifdef PROG_COUNTER_SATURATE_EN
        step_d     = ZERO_W;
`else
        step_d     = MAX_W;
`endif
      end else begin
        step_d     = count_q - ONE_W;
      end
    end
  end

  // Input synchronisers, load FSM, counter and terminal-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      dir_q       <= 1'b0;
      load_q      <= 1'b0;
      load_hist_q <= 1'b0;
      oe_q        <= 1'b0;
      state_q     <= S_IDLE;
      turn_cnt_q  <= 4'd0;
      count_q     <= ZERO_W;
      tc_q        <= 1'b0;
    end else begin
      en_q        <= en_i;
      dir_q       <= dir_i;
      load_q      <= load_i;
      load_hist_q <= load_q;
      oe_q        <= oe_i;
      case (state_q)
        S_IDLE: begin
          if (load_pulse_s) begin
            state_q    <= S_RELEASE;
            turn_cnt_q <= TURN_INIT;
          end else begin
            state_q    <= S_IDLE;
          end
          if (en_q) begin
            count_q <= step_d;
            tc_q    <= step_lim_d;
          end else begin
            tc_q    <= 1'b0;
          end
        end
        // Counter is frozen while the bus turns around; load edges are ignored.
        S_RELEASE: begin
          tc_q <= 1'b0;
          if (turn_cnt_q == 4'd0) begin
            state_q    <= S_CAPTURE;
          end else begin
            turn_cnt_q <= turn_cnt_q - 4'd1;
          end
        end
        // Captured value takes priority over any pending step.
        S_CAPTURE: begin
          count_q <= bus_in_i;
          tc_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          tc_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign count_o   = count_q;
  assign bus_out_o = count_q;
  assign tc_o      = tc_q;
  assign busy_o    = (state_q != S_IDLE);
  // The bus is driven only from IDLE, so the driver never contends with CAPTURE.
  assign bus_oe_o  = {WIDTH{(state_q == S_IDLE) & oe_q}};

endmodule
